// File: rtl/uart_alu_if.sv
// Bundle of the UART/ALU-facing signals around the operand sequencer.
// Ports: rx_done_tick/rx_data (received byte), alu_result (combinational ALU),
//        tx_done_tick (frame sent), data_a/data_b/op_code/tx_start/tx_data/overrun.
interface uart_alu_if #(
  parameter int DBIT  = 8,
  parameter int NB_OP = 6
);
  logic             rx_done_tick;
  logic [DBIT-1:0]  rx_data;
  logic [DBIT-1:0]  alu_result;
  logic             tx_done_tick;
  logic [DBIT-1:0]  data_a;
  logic [DBIT-1:0]  data_b;
  logic [NB_OP-1:0] op_code;
  logic             tx_start;
  logic [DBIT-1:0]  tx_data;
  logic             overrun;

  // Environment side: UART receiver/transmitter and the ALU.
  modport master (
    output rx_done_tick, rx_data, alu_result, tx_done_tick,
    input  data_a, data_b, op_code, tx_start, tx_data, overrun
  );

  // Sequencer side.
  modport slave (
    input  rx_done_tick, rx_data, alu_result, tx_done_tick,
    output data_a, data_b, op_code, tx_start, tx_data, overrun
  );
endinterface

// File: rtl/uart_alu_interface.sv
// Collects operand A, operand B and opcode bytes from a UART receiver, latches
// the ALU result and hands it to the UART transmitter, then waits for the frame.
// Ports: clk, reset (async active-low), bus (uart_alu_if.slave).
// Latency: tx_start rises two cycles after the opcode strobe; bytes arriving
// while a result is in flight are dropped and flagged in sticky overrun.
module uart_alu_interface #(
  parameter int DBIT  = 8,
  parameter int NB_OP = 6
) (
  input  logic       clk,
  input  logic       reset,
  uart_alu_if.slave  bus
);

  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    GET_B   = 3'd1,
    GET_OP  = 3'd2,
    LOAD    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  state_t state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= GET_A;
      bus.data_a   <= '0;
      bus.data_b   <= '0;
      bus.op_code  <= '0;
      bus.tx_data  <= '0;
      bus.tx_start <= 1'b0;
      bus.overrun  <= 1'b0;
    end else begin
      // tx_start is only raised on the LOAD->SEND edge, so it is high
      // exactly while the FSM sits in SEND.
      bus.tx_start <= 1'b0;
      case (state)
        GET_A: begin
          if (bus.rx_done_tick) begin
            bus.data_a <= bus.rx_data;
            state      <= GET_B;
          end
        end
        GET_B: begin
          if (bus.rx_done_tick) begin
            bus.data_b <= bus.rx_data;
            state      <= GET_OP;
          end
        end
        GET_OP: begin
          if (bus.rx_done_tick) begin
            bus.op_code <= bus.rx_data[NB_OP-1:0];
            state       <= LOAD;
          end
        end
        LOAD: begin
          // Operands are stable for a full cycle here, so the ALU has settled.
          bus.tx_data  <= bus.alu_result[DBIT-1:0];
          bus.tx_start <= 1'b1;
          state        <= SEND;
        end
        SEND: begin
          state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (bus.tx_done_tick) begin
            state <= GET_A;
          end
        end
        default: begin
          state <= GET_A;
        end
      endcase

      // A byte received while the result is being processed or sent has
      // nowhere to go; drop it and remember that it happened.
      if (bus.rx_done_tick && (state == LOAD || state == SEND || state == WAIT_TX)) begin
        bus.overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_alu_interface.sv
module tb_uart_alu_interface;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic model_ovr;

  uart_alu_if #(.DBIT(8), .NB_OP(6)) bus ();

  // ALU stub: plain addition of the two operands.
  assign bus.alu_result = bus.data_a + bus.data_b;

  uart_alu_interface #(.DBIT(8), .NB_OP(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] exp_op;
    logic [7:0] exp_tx;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; presents one byte strobe for one clock cycle.
  task automatic strobe_rx(input logic [7:0] b);
    bus.rx_done_tick = 1'b1;
    bus.rx_data      = b;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'($urandom);
  endtask

  task automatic gap_cycles(input int n, input bit stray, input string tag);
    for (int i = 0; i < n; i++) begin
      bus.tx_done_tick = stray && (i == 0);
      @(negedge clk);
      bus.tx_done_tick = 1'b0;
      if (stray) check({tag, ":gap_tx_start"}, 32'(bus.tx_start), 32'd0);
    end
  endtask

  // wait_mode: 0 = plain tx_done, 1 = stray byte 0x7F in WAIT_TX then tx_done,
  //            2 = byte 0x55 and tx_done in the same cycle.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input logic [7:0] exp_op, input logic [7:0] exp_tx,
                         input int gap, input bit stray, input int wait_mode,
                         input logic exp_ovr, input string tag);
    strobe_rx(a);
    gap_cycles(gap, stray, tag);
    strobe_rx(b);
    gap_cycles(gap, stray, tag);
    strobe_rx(op);
    // Cycle after the opcode strobe: LOAD
    check({tag, ":tx_start_load"}, 32'(bus.tx_start), 32'd0);
    check({tag, ":data_a"},  32'(bus.data_a),  32'(a));
    check({tag, ":data_b"},  32'(bus.data_b),  32'(b));
    check({tag, ":op_code"}, 32'(bus.op_code), 32'(exp_op));
    @(negedge clk);
    // Two cycles after the opcode strobe: SEND
    check({tag, ":tx_start_send"}, 32'(bus.tx_start), 32'd1);
    check({tag, ":tx_data"}, 32'(bus.tx_data), 32'(exp_tx));
    @(negedge clk);
    check({tag, ":tx_start_wait"}, 32'(bus.tx_start), 32'd0);
    if (wait_mode == 2) begin
      bus.rx_done_tick = 1'b1;
      bus.rx_data      = 8'h55;
      bus.tx_done_tick = 1'b1;
      @(negedge clk);
      bus.rx_done_tick = 1'b0;
      bus.tx_done_tick = 1'b0;
    end else begin
      if (wait_mode == 1) begin
        strobe_rx(8'h7F);
        check({tag, ":data_a_after_drop"}, 32'(bus.data_a), 32'(a));
      end
      bus.tx_done_tick = 1'b1;
      @(negedge clk);
      bus.tx_done_tick = 1'b0;
    end
    check({tag, ":overrun"},    32'(bus.overrun), 32'(exp_ovr));
    check({tag, ":data_a_hold"}, 32'(bus.data_a), 32'(a));
    check({tag, ":tx_data_hold"}, 32'(bus.tx_data), 32'(exp_tx));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ":data_a"},   32'(bus.data_a),   32'd0);
    check({tag, ":data_b"},   32'(bus.data_b),   32'd0);
    check({tag, ":op_code"},  32'(bus.op_code),  32'd0);
    check({tag, ":tx_data"},  32'(bus.tx_data),  32'd0);
    check({tag, ":tx_start"}, 32'(bus.tx_start), 32'd0);
    check({tag, ":overrun"},  32'(bus.overrun),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_ovr = 1'b0;

    tbl[0] = '{a: 8'h05, b: 8'h03, op: 8'h20, exp_op: 8'h20, exp_tx: 8'h08};
    tbl[1] = '{a: 8'hFF, b: 8'h01, op: 8'hE4, exp_op: 8'h24, exp_tx: 8'h00};
    tbl[2] = '{a: 8'h80, b: 8'h80, op: 8'h3F, exp_op: 8'h3F, exp_tx: 8'h00};
    tbl[3] = '{a: 8'h00, b: 8'h00, op: 8'h00, exp_op: 8'h00, exp_tx: 8'h00};
    tbl[4] = '{a: 8'h12, b: 8'h34, op: 8'hC1, exp_op: 8'h01, exp_tx: 8'h46};
    tbl[5] = '{a: 8'hFE, b: 8'hFE, op: 8'h40, exp_op: 8'h00, exp_tx: 8'hFC};

    reset            = 1'b0;
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
    bus.tx_done_tick = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // Directed vectors
    foreach (tbl[i]) begin
      run_txn(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp_op, tbl[i].exp_tx,
              i % 2, 1'b0, 0, 1'b0, $sformatf("vec%0d", i));
    end

    // Stray tx_done_tick in GET_A / GET_B must be ignored
    run_txn(8'h21, 8'h43, 8'h05, 8'h05, 8'h64, 2, 1'b1, 0, 1'b0, "stray_tx");

    // Byte dropped in WAIT_TX sets sticky overrun; next sequence still works
    run_txn(8'h05, 8'h03, 8'h20, 8'h20, 8'h08, 0, 1'b0, 1, 1'b1, "ovr_drop");
    run_txn(8'h01, 8'h02, 8'h20, 8'h20, 8'h03, 0, 1'b0, 0, 1'b1, "ovr_after");

    // Reset in the middle of a sequence
    strobe_rx(8'h11);
    strobe_rx(8'h22);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    run_txn(8'h0A, 8'h0B, 8'h20, 8'h20, 8'h15, 0, 1'b0, 0, 1'b0, "post_reset");

    // Simultaneous rx and tx done in WAIT_TX
    run_txn(8'h33, 8'h44, 8'h02, 8'h02, 8'h77, 0, 1'b0, 2, 1'b1, "simul");
    run_txn(8'h0C, 8'h0D, 8'h01, 8'h01, 8'h19, 0, 1'b0, 0, 1'b1, "after_simul");

    // Random phase against the reference model
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_ovr = 1'b0;
    for (int t = 0; t < 25; t++) begin
      logic [7:0] ra, rb, rop, eop, etx;
      int rgap, rmode;
      bit rstray;
      ra    = 8'($urandom);
      rb    = 8'($urandom);
      rop   = 8'($urandom);
      rgap  = int'($urandom_range(0, 3));
      rstray = (rgap > 0) && ($urandom_range(0, 1) == 1);
      rmode = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      eop   = rop % 64;
      etx   = 8'((int'(ra) + int'(rb)) % 256);
      if (rmode != 0) model_ovr = 1'b1;
      run_txn(ra, rb, rop, eop, etx, rgap, rstray, rmode, model_ovr,
              $sformatf("rand%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_alu_interface.md
UART_ALU_INTERFACE -- requirements
Module: uart_alu_interface

Interface
REQ-001 Parameter DBIT, default 8, SHALL be the data byte width.
REQ-002 Parameter NB_OP, default 6, SHALL be the opcode width (NB_OP <= DBIT).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 rx_done_tick  input  1  SHALL be a one-cycle strobe from the UART receiver marking a valid byte.
REQ-006 rx_data  input  DBIT  SHALL be the received byte, valid while rx_done_tick=1.
REQ-007 alu_result  input  DBIT  SHALL be the combinational ALU output driven from data_a, data_b and op_code.
REQ-008 tx_done_tick  input  1  SHALL be a one-cycle strobe from the UART transmitter marking end of frame.
REQ-009 data_a  output  DBIT  SHALL be the registered operand A.
REQ-010 data_b  output  DBIT  SHALL be the registered operand B.
REQ-011 op_code  output  NB_OP  SHALL be the registered opcode.
REQ-012 tx_start  output  1  SHALL be the one-cycle transmit request.
REQ-013 tx_data  output  DBIT  SHALL be the registered result byte for the transmitter.
REQ-014 overrun  output  1  SHALL be a sticky flag marking a received byte that was dropped.

Function
REQ-015 FSM SHALL have six states: GET_A, GET_B, GET_OP, LOAD, SEND, WAIT_TX.
REQ-016 GET_A: rx_done_tick=1 SHALL load data_a<=rx_data and go to GET_B at that edge; otherwise hold.
REQ-017 GET_B: rx_done_tick=1 SHALL load data_b<=rx_data and go to GET_OP; otherwise hold.
REQ-018 GET_OP: rx_done_tick=1 SHALL load op_code<=rx_data[NB_OP-1:0], discard upper bits, and go to LOAD.
REQ-019 LOAD SHALL last exactly one cycle, load tx_data<=alu_result at its closing edge, and go to SEND.
REQ-020 SEND SHALL last exactly one cycle with tx_start=1 (Moore output; tx_start=0 in all other states), then go to WAIT_TX.
REQ-021 WAIT_TX: tx_done_tick=1 SHALL return to GET_A; otherwise hold.
REQ-022 Latency: tx_start SHALL be high exactly two cycles after the cycle where the opcode byte's rx_done_tick is high.
REQ-023 tx_data SHALL hold its value from LOAD until the next LOAD; data_a, data_b, op_code SHALL hold until their next capture.
REQ-024 rx_done_tick in LOAD, SEND or WAIT_TX SHALL be ignored (no register change, no state change) and SHALL set overrun=1.
REQ-025 overrun SHALL stay 1 until reset.
REQ-026 tx_done_tick outside WAIT_TX SHALL be ignored.
REQ-027 rx_done_tick and tx_done_tick together in WAIT_TX SHALL go to GET_A, set overrun, and not capture the byte.

Reset
REQ-028 reset=0 SHALL immediately, independent of clk, force state=GET_A and data_a=data_b=tx_data=0, op_code=0, overrun=0, tx_start=0.
REQ-029 Reset asserted in any state, including mid-sequence, SHALL discard partially received operands; the next byte after release SHALL be treated as A.
REQ-030 After reset release, first rising edge SHALL be evaluated normally (no dead cycle).

Verification
REQ-031 Bytes 0x05, 0x03, 0x20 with ALU stub returning data_a+data_b -> data_a=0x05, data_b=0x03, op_code=0x20, tx_data=0x08, one-cycle tx_start two cycles after third strobe.
REQ-032 Opcode byte 0xE4 -> op_code=0x24 (upper two bits dropped).
REQ-033 Byte 0x7F strobed during WAIT_TX -> overrun=1, data_a unchanged; after tx_done_tick, bytes 0x01,0x02,0x20 -> tx_data=0x03.
REQ-034 reset=0 after A=0x11, B=0x22 -> all outputs 0 asynchronously; then 0x0A,0x0B,0x20 -> tx_data=0x15.
REQ-035 tx_done_tick pulsed in GET_A and GET_B -> no state change, tx_start stays 0.
REQ-036 Simultaneous rx_done_tick=1 (0x55) and tx_done_tick=1 in WAIT_TX -> state GET_A, overrun=1, data_a not loaded with 0x55.
